// File: rtl/apx_err_accum.sv
// rtl/apx_err_accum.sv - windowed error statistics between accurate and approximate products
//
// Optional build macro: APX_ERR_SQ_EN adds the sum_sq_err output (sum of squared errors).
//
// One window = WINDOW accepted (acc_c, apx_c) pairs. Results update live while
// accumulating and are frozen under out_valid until the consumer takes them.
// Results then stay readable in IDLE until the next start clears them.
module apx_err_accum #(
   parameter int WIDTH  = 32,
   parameter int WINDOW = 500,
   parameter int CNT_W  = 16,
   parameter int SUM_W  = 48
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         acc_c,
   input  logic [WIDTH-1:0]         apx_c,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SUM_W-1:0]         sum_abs_err,
   output logic [WIDTH-1:0]         max_abs_err,
   output logic [CNT_W-1:0]         mismatch_cnt,
`ifdef APX_ERR_SQ_EN
   output logic [2*WIDTH+CNT_W-1:0] sum_sq_err,
`endif
   output logic                     busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_REPORT = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_in_ready;
   logic              r_out_valid;
   logic              r_busy;
   logic [CNT_W-1:0]  r_cnt;
   logic [SUM_W-1:0]  r_sum;
   logic [WIDTH-1:0]  r_max;
   logic [CNT_W-1:0]  r_mis;

   logic [WIDTH-1:0]  w_d;
   logic [SUM_W:0]    w_sum_ext;
   logic [SUM_W-1:0]  w_sum_next;
   logic [WIDTH-1:0]  w_max_next;
   logic [CNT_W-1:0]  w_mis_next;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_last;

`ifdef APX_ERR_SQ_EN
   localparam int SQ_W = 2*WIDTH + CNT_W;
   logic [SQ_W-1:0]     r_sq;
   logic [2*WIDTH-1:0]  w_d_ext;
   logic [2*WIDTH-1:0]  w_sq_term;
   logic [SQ_W-1:0]     w_sq_next;
`endif

   // Per-sample datapath: absolute difference and the next value of every statistic.
   always_comb begin
      w_d        = (acc_c >= apx_c) ? (acc_c - apx_c) : (apx_c - acc_c);
      // One spare carry bit detects overflow; the accumulator then pins at all-ones.
      w_sum_ext  = {1'b0, r_sum} + {{(SUM_W+1-WIDTH){1'b0}}, w_d};
      w_sum_next = w_sum_ext[SUM_W] ? {SUM_W{1'b1}} : w_sum_ext[SUM_W-1:0];
      w_max_next = (w_d > r_max) ? w_d : r_max;
      w_mis_next = r_mis + {{(CNT_W-1){1'b0}}, (w_d != '0)};
      w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      // The pair being accepted now is the one that completes the window.
      w_last     = (r_cnt == CNT_W'(WINDOW - 1));
`ifdef APX_ERR_SQ_EN
      // Widen before multiplying so the square keeps all 2*WIDTH bits.
      w_d_ext    = {{WIDTH{1'b0}}, w_d};
      w_sq_term  = w_d_ext * w_d_ext;
      w_sq_next  = r_sq + {{CNT_W{1'b0}}, w_sq_term};
`endif
   end

   // Control FSM with registered handshake/status outputs and the result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_cnt       <= '0;
         r_sum       <= '0;
         r_max       <= '0;
         r_mis       <= '0;
`ifdef APX_ERR_SQ_EN
         r_sq        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_ACCUM;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_cnt      <= '0;
                  r_sum      <= '0;
                  r_max      <= '0;
                  r_mis      <= '0;
`ifdef APX_ERR_SQ_EN
                  r_sq       <= '0;
`endif
               end
            end
            S_ACCUM: begin
               // in_ready is high throughout ACCUM, so in_valid alone means accepted.
               if (in_valid) begin
                  r_cnt <= w_cnt_next;
                  r_sum <= w_sum_next;
                  r_max <= w_max_next;
                  r_mis <= w_mis_next;
`ifdef APX_ERR_SQ_EN
                  r_sq  <= w_sq_next;
`endif
                  if (w_last) begin
                     r_state     <= S_REPORT;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            S_REPORT: begin
               // start during the handshake is deliberately ignored; it must come in IDLE.
               if (out_ready) begin
                  r_state     <= S_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_in_ready  <= 1'b0;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_out_valid;
   assign busy         = r_busy;
   assign sum_abs_err  = r_sum;
   assign max_abs_err  = r_max;
   assign mismatch_cnt = r_mis;
`ifdef APX_ERR_SQ_EN
   assign sum_sq_err   = r_sq;
`endif

endmodule

// File: tb/tb_apx_err_accum.sv
// tb/tb_apx_err_accum.sv - self-checking bench for apx_err_accum (table vectors plus randomized model)
module tb_apx_err_accum;

   localparam int WIDTH  = 32;
   localparam int WINDOW = 4;
   localparam int CNT_W  = 16;
   localparam int SUM_W  = 48;
   localparam int SAT_W  = 33;
   localparam int SQ_W   = 2*WIDTH + CNT_W;

   logic              clk;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  acc_c;
   logic [WIDTH-1:0]  apx_c;

   logic              in_ready, out_valid, busy;
   logic [SUM_W-1:0]  sum_abs_err;
   logic [WIDTH-1:0]  max_abs_err;
   logic [CNT_W-1:0]  mismatch_cnt;

   logic              s_in_ready, s_out_valid, s_busy;
   logic [SAT_W-1:0]  s_sum;
   logic [WIDTH-1:0]  s_max;
   logic [CNT_W-1:0]  s_mis;
`ifdef APX_ERR_SQ_EN
   logic [SQ_W-1:0]   sum_sq_err;
   logic [SQ_W-1:0]   s_sq;
`endif

   apx_err_accum #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .acc_c(acc_c), .apx_c(apx_c), .out_valid(out_valid), .out_ready(out_ready),
      .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .mismatch_cnt(mismatch_cnt),
`ifdef APX_ERR_SQ_EN
      .sum_sq_err(sum_sq_err),
`endif
      .busy(busy)
   );

   // Narrow accumulator instance so saturation is reachable inside a 4-sample window.
   apx_err_accum #(.WIDTH(WIDTH), .WINDOW(WINDOW), .CNT_W(CNT_W), .SUM_W(SAT_W)) u_dut_sat (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
      .acc_c(acc_c), .apx_c(apx_c), .out_valid(s_out_valid), .out_ready(out_ready),
      .sum_abs_err(s_sum), .max_abs_err(s_max), .mismatch_cnt(s_mis),
`ifdef APX_ERR_SQ_EN
      .sum_sq_err(s_sq),
`endif
      .busy(s_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 idle, 1 collecting, 2 results offered; list of window errors.
   int               m_phase = 0;
   logic [WIDTH-1:0] m_d[$];

   typedef struct packed {
      logic [3:0][WIDTH-1:0] a;
      logic [3:0][WIDTH-1:0] b;
      logic [SUM_W-1:0]      e_sum;
      logic [WIDTH-1:0]      e_max;
      logic [CNT_W-1:0]      e_mis;
      logic [SQ_W-1:0]       e_sq;
      logic [SAT_W-1:0]      e_sat;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string nm, input logic [SQ_W-1:0] act, input logic [SQ_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic s, input logic iv, input logic ordy,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (r) begin
         m_phase = 0;
         m_d.delete();
      end else if (m_phase == 0) begin
         if (s) begin
            m_phase = 1;
            m_d.delete();
         end
      end else if (m_phase == 1) begin
         if (iv) begin
            m_d.push_back((a >= b) ? a - b : b - a);
            if (m_d.size() == WINDOW) m_phase = 2;
         end
      end else if (ordy) begin
         m_phase = 0;
      end
   endtask

   task automatic check_all();
      logic [SQ_W-1:0]  raw;
      logic [SQ_W-1:0]  sq;
      logic [WIDTH-1:0] mx;
      logic [CNT_W-1:0] mis;
      logic [SQ_W-1:0]  lim48;
      logic [SQ_W-1:0]  lim33;
      logic [SQ_W-1:0]  dd;
      raw = '0; sq = '0; mx = '0; mis = '0;
      foreach (m_d[i]) begin
         raw += SQ_W'(m_d[i]);
         dd   = SQ_W'(m_d[i]);
         sq  += dd * dd;
         if (m_d[i] > mx) mx = m_d[i];
         if (m_d[i] != 0) mis++;
      end
      lim48 = (SQ_W'(1) << SUM_W) - 1;
      lim33 = (SQ_W'(1) << SAT_W) - 1;
      chk("in_ready",  SQ_W'(in_ready),  SQ_W'(m_phase == 1));
      chk("out_valid", SQ_W'(out_valid), SQ_W'(m_phase == 2));
      chk("busy",      SQ_W'(busy),      SQ_W'(m_phase != 0));
      chk("sum",       SQ_W'(sum_abs_err), (raw > lim48) ? lim48 : raw);
      chk("max",       SQ_W'(max_abs_err), SQ_W'(mx));
      chk("mismatch",  SQ_W'(mismatch_cnt), SQ_W'(mis));
      chk("sat_sum",   SQ_W'(s_sum), (raw > lim33) ? lim33 : raw);
      chk("sat_ctrl",  SQ_W'({s_in_ready, s_out_valid, s_busy}), SQ_W'({in_ready, out_valid, busy}));
      chk("sat_stats", SQ_W'({s_max, s_mis}), SQ_W'({mx, mis}));
`ifdef APX_ERR_SQ_EN
      chk("sum_sq",    sum_sq_err, sq);
      chk("sat_sq",    s_sq, sq);
`endif
   endtask

   // Apply inputs, clock once, advance the model, then compare after the edge.
   task automatic cyc(input logic r, input logic s, input logic iv, input logic ordy,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      rst = r; start = s; in_valid = iv; out_ready = ordy; acc_c = a; apx_c = b;
      @(posedge clk);
      model_step(r, s, iv, ordy, a, b);
      #1;
      check_all();
   endtask

   function automatic logic [WIDTH-1:0] rnd_b(input logic [WIDTH-1:0] a);
      case ($urandom_range(0, 3))
         0: return a;
         1: return a + $urandom_range(0, 50);
         2: return a - $urandom_range(0, 50);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [WIDTH-1:0] ra;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; acc_c = '0; apx_c = '0;

      for (int i = 0; i < 4; i++) begin
         tbl[i].e_sq = '0;
         for (int k = 0; k < 4; k++) begin
            tbl[i].a[k] = '0;
            tbl[i].b[k] = '0;
         end
      end
      for (int k = 0; k < 4; k++) begin
         tbl[0].a[k] = 32'h12345678; tbl[0].b[k] = 32'h12345678;
         tbl[2].a[k] = 32'd1;        tbl[2].b[k] = 32'd0;
         tbl[3].a[k] = 32'hFFFFFFFF; tbl[3].b[k] = 32'd0;
      end
      tbl[0].e_sum = 48'd0;  tbl[0].e_max = 32'd0; tbl[0].e_mis = 16'd0;
      tbl[0].e_sq  = '0;     tbl[0].e_sat = 33'd0;
      tbl[1].a[0] = 32'd100;        tbl[1].b[0] = 32'd90;
      tbl[1].a[1] = 32'd5;          tbl[1].b[1] = 32'd20;
      tbl[1].a[2] = 32'd7;          tbl[1].b[2] = 32'd7;
      tbl[1].a[3] = 32'hFFFFFFFF;   tbl[1].b[3] = 32'd0;
      tbl[1].e_sum = 48'h1_0000_0018; tbl[1].e_max = 32'hFFFFFFFF; tbl[1].e_mis = 16'd3;
      tbl[1].e_sq  = 80'hFFFF_FFFE_0000_0146; tbl[1].e_sat = 33'h1_0000_0018;
      tbl[2].e_sum = 48'd4;  tbl[2].e_max = 32'd1; tbl[2].e_mis = 16'd4;
      tbl[2].e_sq  = 80'd4;  tbl[2].e_sat = 33'd4;
      tbl[3].e_sum = 48'h3_FFFF_FFFC; tbl[3].e_max = 32'hFFFFFFFF; tbl[3].e_mis = 16'd4;
      tbl[3].e_sq  = 80'h3_FFFF_FFF8_0000_0004; tbl[3].e_sat = 33'h1_FFFF_FFFF;

      // Reset held 3 cycles with random inputs.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
      chk("rst_zero", SQ_W'({in_ready, out_valid, busy, sum_abs_err, max_abs_err, mismatch_cnt}), '0);
      // in_valid pulses in IDLE are ignored.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd9, 32'd1);
      chk("idle_ignore", SQ_W'({busy, sum_abs_err}), '0);

      // Table-driven windows, each followed by a handshake.
      for (int v = 0; v < 4; v++) begin
         cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
         chk("tbl_start_ready", SQ_W'({in_ready, busy}), SQ_W'(2'b11));
         for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, tbl[v].a[k], tbl[v].b[k]);
         chk("tbl_out_valid", SQ_W'({out_valid, in_ready}), SQ_W'(2'b10));
         chk("tbl_sum",  SQ_W'(sum_abs_err),  SQ_W'(tbl[v].e_sum));
         chk("tbl_max",  SQ_W'(max_abs_err),  SQ_W'(tbl[v].e_max));
         chk("tbl_mis",  SQ_W'(mismatch_cnt), SQ_W'(tbl[v].e_mis));
         chk("tbl_sat",  SQ_W'(s_sum),        SQ_W'(tbl[v].e_sat));
`ifdef APX_ERR_SQ_EN
         chk("tbl_sq",   sum_sq_err, tbl[v].e_sq);
`endif
         cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
         chk("tbl_idle", SQ_W'({out_valid, busy}), '0);
         chk("tbl_hold", SQ_W'(sum_abs_err), SQ_W'(tbl[v].e_sum));
      end

      // Backpressure: REPORT held 10 cycles with in_valid driven, start during the handshake ignored.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, tbl[1].a[k], tbl[1].b[k]);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd1000, 32'd1);
      chk("bp_stable", SQ_W'(sum_abs_err), SQ_W'(tbl[1].e_sum));
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 32'd5, 32'd0);
      chk("bp_release", SQ_W'({busy, in_ready}), '0);

      // Input gaps: in_valid toggles; exactly 4 samples taken.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'(i % 2 == 0), 1'b0, 32'd10 + 32'(i), 32'd3);
      chk("gap_mis", SQ_W'(mismatch_cnt), SQ_W'(4));
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

      // Reset mid-window, then a fresh window of (1,0) pairs.
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd50, 32'd7);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd60, 32'd7);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd70, 32'd7);
      chk("mid_rst", SQ_W'({busy, in_ready, sum_abs_err, mismatch_cnt}), '0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
      for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd0);
      chk("mid_rst_sum", SQ_W'({sum_abs_err, max_abs_err, mismatch_cnt}),
          SQ_W'({48'd4, 32'd1, 16'd4}));
      cyc(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         ra = $urandom;
         cyc(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), ra, rnd_b(ra));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
